// File: rtl/mem_access_ctrl.sv
// -----------------------------------------------------------------------------
// mem_access_ctrl
//
// Initiator-side controller between the datapath's MAR/MDR and a 512x32 RAM.
// The controller accepts one load or one store at a time. It holds the RAM
// strobes, address and write data stable until the RAM raises done. On a load
// it captures the read data. It then returns a one-cycle acknowledge with an
// error flag. A watchdog aborts an access if done never arrives. A request
// with both read and write asserted is rejected without touching the RAM.
//
// Ports:
//   clock        system clock, all state changes on the rising edge
//   clear        synchronous active-high reset
//   req_read     load request, sampled only in IDLE
//   req_write    store request, sampled only in IDLE
//   req_address  word address from MAR
//   req_data     store data from MDR
//   busy         high in every state except IDLE
//   ack          one-cycle pulse when a request finishes
//   error        valid with ack: timeout or illegal request
//   rd_data      last successful load result
//   ram_enable   RAM enable
//   ram_read     RAM read strobe
//   ram_write    RAM write strobe
//   ram_address  RAM word address
//   ram_data_in  RAM write data
//   ram_data_out RAM read data
//   ram_done     RAM completion flag
// -----------------------------------------------------------------------------
module mem_access_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 9,
  parameter int TIMEOUT    = 15   // legal range 1..255
) (
  input  logic                  clock,
  input  logic                  clear,
  input  logic                  req_read,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_address,
  input  logic [DATA_WIDTH-1:0] req_data,
  output logic                  busy,
  output logic                  ack,
  output logic                  error,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  ram_enable,
  output logic                  ram_read,
  output logic                  ram_write,
  output logic [ADDR_WIDTH-1:0] ram_address,
  output logic [DATA_WIDTH-1:0] ram_data_in,
  input  logic [DATA_WIDTH-1:0] ram_data_out,
  input  logic                  ram_done
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCESS,
    S_RESP
  } state_t;

  // Watchdog fires when the counter reaches this value while done is still low.
  localparam logic [7:0] LP_LAST_COUNT = 8'(TIMEOUT - 1);

  state_t                r_state;
  logic [7:0]            r_count;
  logic                  r_busy;
  logic                  r_ack;
  logic                  r_error;
  logic [DATA_WIDTH-1:0] r_rd_data;
  logic                  r_ram_enable;
  logic                  r_ram_read;
  logic                  r_ram_write;
  logic [ADDR_WIDTH-1:0] r_ram_address;
  logic [DATA_WIDTH-1:0] r_ram_data_in;

  // NOTE: all state updates use non-blocking assignments. Every register
  // therefore samples the values from before the edge, whatever the
  // statement order inside the block.
  always_ff @(posedge clock) begin
    if (clear) begin
      // NOTE: rd_data is a single register. It is not a memory array, so it
      // is cleared here together with the rest of the outputs.
      r_state       <= S_IDLE;
      r_count       <= '0;
      r_busy        <= 1'b0;
      r_ack         <= 1'b0;
      r_error       <= 1'b0;
      r_rd_data     <= '0;
      r_ram_enable  <= 1'b0;
      r_ram_read    <= 1'b0;
      r_ram_write   <= 1'b0;
      r_ram_address <= '0;
      r_ram_data_in <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_ack   <= 1'b0;
          r_error <= 1'b0;
          if (req_read && req_write) begin
            // Illegal request: the RAM is not touched; report it right away.
            r_state <= S_RESP;
            r_busy  <= 1'b1;
            r_ack   <= 1'b1;
            r_error <= 1'b1;
          end else if (req_read || req_write) begin
            r_state       <= S_ACCESS;
            r_busy        <= 1'b1;
            r_count       <= '0;
            r_ram_enable  <= 1'b1;
            r_ram_read    <= req_read;
            r_ram_write   <= req_write;
            r_ram_address <= req_address;
            if (req_write) begin
              r_ram_data_in <= req_data;
            end
          end
        end

        S_ACCESS: begin
          // done wins over the watchdog when both happen in the same cycle.
          if (ram_done) begin
            if (r_ram_read) begin
              r_rd_data <= ram_data_out;
            end
            r_error      <= 1'b0;
            r_ack        <= 1'b1;
            r_ram_enable <= 1'b0;
            r_ram_read   <= 1'b0;
            r_ram_write  <= 1'b0;
            r_state      <= S_RESP;
          end else if (r_count == LP_LAST_COUNT) begin
            r_error      <= 1'b1;
            r_ack        <= 1'b1;
            r_ram_enable <= 1'b0;
            r_ram_read   <= 1'b0;
            r_ram_write  <= 1'b0;
            r_state      <= S_RESP;
          end else begin
            r_count <= r_count + 8'd1;
          end
        end

        S_RESP: begin
          // This cycle also guarantees an enable-low gap between accesses.
          r_ack   <= 1'b0;
          r_error <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign busy        = r_busy;
  assign ack         = r_ack;
  assign error       = r_error;
  assign rd_data     = r_rd_data;
  assign ram_enable  = r_ram_enable;
  assign ram_read    = r_ram_read;
  assign ram_write   = r_ram_write;
  assign ram_address = r_ram_address;
  assign ram_data_in = r_ram_data_in;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mem_access_ctrl
//
// Directed bench for mem_access_ctrl. A behavioural 512x32 RAM answers with a
// programmable done delay. The delay can also be disabled to force the
// watchdog. A table of transactions is applied in order. Hand-written
// sequences cover reset at power-up and reset in the middle of an access.
// -----------------------------------------------------------------------------
module tb_mem_access_ctrl;

  localparam int DW = 32;
  localparam int AW = 9;
  localparam int TO = 15;

  logic          clock = 1'b0;
  logic          clear;
  logic          req_read;
  logic          req_write;
  logic [AW-1:0] req_address;
  logic [DW-1:0] req_data;
  logic          busy;
  logic          ack;
  logic          error;
  logic [DW-1:0] rd_data;
  logic          ram_enable;
  logic          ram_read;
  logic          ram_write;
  logic [AW-1:0] ram_address;
  logic [DW-1:0] ram_data_in;
  logic [DW-1:0] ram_data_out;
  logic          ram_done;

  mem_access_ctrl #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW),
    .TIMEOUT   (TO)
  ) dut (
    .clock       (clock),
    .clear       (clear),
    .req_read    (req_read),
    .req_write   (req_write),
    .req_address (req_address),
    .req_data    (req_data),
    .busy        (busy),
    .ack         (ack),
    .error       (error),
    .rd_data     (rd_data),
    .ram_enable  (ram_enable),
    .ram_read    (ram_read),
    .ram_write   (ram_write),
    .ram_address (ram_address),
    .ram_data_in (ram_data_in),
    .ram_data_out(ram_data_out),
    .ram_done    (ram_done)
  );

  always #5 clock = ~clock;

  // ---------------- RAM model ----------------
  // acc_cnt is 0 in the first enabled cycle. done rises in the cycle where
  // acc_cnt equals done_delay, so the RAM answers in ACCESS cycle
  // k = done_delay + 1.
  logic [DW-1:0] mem [512];
  int            acc_cnt = 0;
  int            done_delay = 0;
  bit            done_en = 1'b1;

  assign ram_done     = done_en && ram_enable && (acc_cnt == done_delay);
  assign ram_data_out = mem[ram_address];

  always @(posedge clock) begin
    acc_cnt <= ram_enable ? acc_cnt + 1 : 0;
    if (ram_done && ram_write) mem[ram_address] <= ram_data_in;
  end

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  typedef struct {
    string         name;
    bit            rd;
    bit            wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    int            delay;    // done in ACCESS cycle delay+1
    bit            no_done;  // RAM never answers
    int            exp_lat;  // falling edges from the request to the ack sample
    bit            exp_err;
    logic [DW-1:0] exp_rd;
  } txn_t;

  // The request is driven on a falling edge. The next rising edge accepts it.
  // lat counts falling edges until ack is seen, which gives k+1 for a RAM
  // answer in ACCESS cycle k, TIMEOUT+1 on a watchdog abort, and 1 for an
  // illegal request.
  task automatic run_txn(input txn_t t);
    int lat;
    bit seen;
    @(negedge clock);
    check($sformatf("%s pre ack", t.name), 32'(ack), 32'd0);
    check($sformatf("%s pre busy", t.name), 32'(busy), 32'd0);
    done_delay  = t.delay;
    done_en     = !t.no_done;
    req_read    = t.rd;
    req_write   = t.wr;
    req_address = t.addr;
    req_data    = t.data;
    lat  = 0;
    seen = 1'b0;
    while (!seen && lat < 40) begin
      @(negedge clock);
      lat++;
      if (ack) begin
        seen = 1'b1;
      end else begin
        check($sformatf("%s busy c%0d", t.name, lat), 32'(busy), 32'd1);
        check($sformatf("%s en c%0d", t.name, lat), 32'(ram_enable), 32'(t.rd ^ t.wr));
        check($sformatf("%s rd c%0d", t.name, lat), 32'(ram_read), 32'(t.rd & ~t.wr));
        check($sformatf("%s wr c%0d", t.name, lat), 32'(ram_write), 32'(t.wr & ~t.rd));
        check($sformatf("%s addr c%0d", t.name, lat), 32'(ram_address), 32'(t.addr));
        if (t.wr && !t.rd)
          check($sformatf("%s din c%0d", t.name, lat), ram_data_in, t.data);
      end
    end
    req_read  = 1'b0;
    req_write = 1'b0;
    check($sformatf("%s ack seen", t.name), 32'(seen), 32'd1);
    check($sformatf("%s latency", t.name), 32'(lat), 32'(t.exp_lat));
    check($sformatf("%s error", t.name), 32'(error), 32'(t.exp_err));
    check($sformatf("%s rd_data", t.name), rd_data, t.exp_rd);
    check($sformatf("%s en at ack", t.name), 32'(ram_enable), 32'd0);
    check($sformatf("%s busy at ack", t.name), 32'(busy), 32'd1);
  endtask

  task automatic check_all_zero(input string tag);
    check($sformatf("%s busy", tag), 32'(busy), 32'd0);
    check($sformatf("%s ack", tag), 32'(ack), 32'd0);
    check($sformatf("%s error", tag), 32'(error), 32'd0);
    check($sformatf("%s rd_data", tag), rd_data, 32'd0);
    check($sformatf("%s en", tag), 32'(ram_enable), 32'd0);
    check($sformatf("%s rd", tag), 32'(ram_read), 32'd0);
    check($sformatf("%s wr", tag), 32'(ram_write), 32'd0);
    check($sformatf("%s addr", tag), 32'(ram_address), 32'd0);
    check($sformatf("%s din", tag), ram_data_in, 32'd0);
  endtask

  txn_t vec [7];

  initial begin
    //           name        rd wr addr    data          dly nd  lat  err exp_rd
    vec[0] = '{"store3",     0, 1, 9'd3,   32'hA5A5A5A5, 1,  0,  3,    0, 32'h0};
    vec[1] = '{"load9",      1, 0, 9'd9,   32'h0,        0,  0,  2,    0, 32'hDEADBEEF};
    vec[2] = '{"timeout5",   1, 0, 9'd5,   32'h0,        0,  1,  TO+1, 1, 32'hDEADBEEF};
    vec[3] = '{"illegal",    1, 1, 9'd7,   32'h12345678, 0,  0,  1,    1, 32'hDEADBEEF};
    vec[4] = '{"store511",   0, 1, 9'd511, 32'h00000011, 0,  0,  2,    0, 32'hDEADBEEF};
    vec[5] = '{"load511",    1, 0, 9'd511, 32'h0,        2,  0,  4,    0, 32'h00000011};
    vec[6] = '{"load3",      1, 0, 9'd3,   32'h0,        0,  0,  2,    0, 32'hA5A5A5A5};

    for (int i = 0; i < 512; i++) mem[i] = '0;
    mem[9] = 32'hDEADBEEF;

    clear       = 1'b1;
    req_read    = 1'b0;
    req_write   = 1'b0;
    req_address = '0;
    req_data    = '0;

    // Reset state after two clear cycles.
    repeat (2) @(negedge clock);
    check_all_zero("reset");
    clear = 1'b0;

    // Table-driven transactions, issued back to back.
    for (int i = 0; i < 7; i++) run_txn(vec[i]);

    // The illegal request must not have written address 7.
    check("illegal no write", mem[7], 32'h0);

    // Clear in the middle of an access.
    @(negedge clock);
    done_en     = 1'b0;
    req_read    = 1'b1;
    req_address = 9'd7;
    repeat (3) @(negedge clock);
    check("midop in access", 32'(ram_enable), 32'd1);
    req_read = 1'b0;
    clear    = 1'b1;
    @(negedge clock);
    check_all_zero("midop clear");
    clear = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clock);
      check($sformatf("midop no ack c%0d", c), 32'(ack), 32'd0);
      check($sformatf("midop idle c%0d", c), 32'(busy), 32'd0);
    end
    run_txn('{"post clear load9", 1, 0, 9'd9, 32'h0, 0, 0, 2, 0, 32'hDEADBEEF});

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
